// File: rtl/cpu_pkg.sv
// cpu_pkg: register-file widths and the packed write-back entry shared by the write-back slice
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int REG_COUNT = 32;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] address;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_fifo.sv
// writeback_fifo: DEPTH-entry circular FIFO of wb_entry_t buffering long-latency results
// Ports: clock, reset (async active-low), push/push_entry, pop/head (show-ahead), count (occupancy).
module writeback_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           push,
  input  wb_entry_t      push_entry,
  input  logic           pop,
  output wb_entry_t      head,
  output logic [PTR_W:0] count
);
  wb_entry_t mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= push_entry;
endmodule

// File: rtl/register_writeback.sv
// register_writeback: sole register-file write port, merging pipeline results with buffered long-latency results
// Ports: clock, reset (async active-low); alu_* pipeline result (always accepted); long_* result with long_ready;
//   write_enable/write_address/write_data registered to the register file; stall_request asks upstream to idle
//   the pipeline so the FIFO drains; fifo_count is the FIFO occupancy.
// Option REGISTER_WRITEBACK_PENDING_EN adds claim_valid/claim_address and the pending outstanding-result mask.
module register_writeback
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 3,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_address,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  long_valid,
  output logic                  long_ready,
  input  logic [REG_ADDR_W-1:0] long_address,
  input  logic [DATA_W-1:0]     long_data,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0]     write_data,
  output logic                  stall_request,
`ifdef REGISTER_WRITEBACK_PENDING_EN
  input  logic                  claim_valid,
  input  logic [REG_ADDR_W-1:0] claim_address,
  output logic [REG_COUNT-1:0]  pending,
`endif
  output logic [CNT_W-1:0]      fifo_count
);
  wb_entry_t head;
  logic alu_issue, fifo_empty, push, pop;
  logic [STARVE_W-1:0] starve;
  assign long_ready = fifo_count != CNT_W'(DEPTH);
  assign fifo_empty = fifo_count == '0;
  assign alu_issue = alu_valid && alu_address != '0;
  // writes to r0 are still consumed so the producer is not held up
  assign push = long_valid && long_ready && long_address != '0;
  assign pop = !alu_issue && !fifo_empty;
  writeback_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock,
    .reset,
    .push,
    .push_entry({long_address, long_data}),
    .pop,
    .head,
    .count(fifo_count)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      stall_request <= 1'b0;
      starve        <= '0;
    end else begin
      write_enable <= alu_issue || pop;
      if (alu_issue) begin
        write_address <= alu_address;
        write_data    <= alu_data;
      end else if (pop) begin
        write_address <= head.address;
        write_data    <= head.data;
      end
      starve <= (fifo_empty || pop) ? '0 : (starve == STARVE_W'(STARVE_LIMIT) ? starve : starve + 1'b1);
      // once raised, the stall holds until the FIFO has been seen empty
      stall_request <= fifo_empty ? 1'b0 : (stall_request || starve == STARVE_W'(STARVE_LIMIT));
    end
`ifdef REGISTER_WRITEBACK_PENDING_EN
  logic [REG_COUNT-1:0] set_mask, clr_mask;
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (claim_valid) set_mask[claim_address] = 1'b1;
    if (pop) clr_mask[head.address] = 1'b1;
  end
  // set applied after clear so a same-edge claim wins; bit 0 forced low
  always_ff @(posedge clock or negedge reset)
    if (!reset) pending <= '0;
    else pending <= ((pending & ~clr_mask) | set_mask) & {{(REG_COUNT-1){1'b1}}, 1'b0};
`endif
endmodule
